memory_access_stage: RTL and testbench
======================================

MEMORY_ACCESS_STAGE -- requirements
Module: memory_access_stage

Interface
REQ-001 Clock/reset: one clock; reset is synchronous and active-high.
REQ-002 clk  in  1  rising-edge clock.
REQ-003 reset  in  1  synchronous, active-high reset.
REQ-004 Instruction  in  32  current instruction; [4:0] = destination register Rt/Rd.
REQ-005 BranchAddress  in  64  computed branch target.
REQ-006 Results  in  64  ALU result; data-memory address.
REQ-007 Data2  in  64  store data.
REQ-008 zero  in  1  ALU result-is-zero flag.
REQ-009 B, BZ, BNZ  in  1 each  unconditional / branch-if-zero / branch-if-nonzero.
REQ-010 MemRead, MemWrite, MemtoReg, RegWrite  in  1 each  memory and write-back controls.
REQ-011 ALUOp  in  2  ALU operation class.
REQ-012 ALUInst  out  4  decoded ALU operation, combinational.
REQ-013 oldBranchAddress  out  64  registered branch target.
REQ-014 PCSrc  out  1  registered branch-taken.
REQ-015 oldRegWrite  out  1  registered RegWrite.
REQ-016 Data2Write  out  64  registered write-back data.
REQ-017 Reg2Write  out  5  registered destination register.

Function
REQ-018 ALUInst decode, combinational, from Instruction[31:21] = op:
- ALUOp 00: 0010.
- ALUOp 01: 0111.
- ALUOp 10, full 11-bit op:
  - ADD 10001011000 -> 0010
  - SUB 11001011000 -> 0110
  - AND 10001010000 -> 0000
  - ORR 10101010000 -> 0001
- ALUOp 11, op[10:1]:
  - ADDI 1001000100 -> 0010
  - SUBI 1101000100 -> 0110
  - ANDI 1001001000 -> 0000
  - ORRI 1011001000 -> 0001
- Any unlisted op: 1111.
REQ-019 Data memory: 32 x 64-bit words; index = Results[7:3]; Results[2:0] and Results[63:8] ignored, so addresses wrap modulo 256 bytes.
REQ-020 On each rising edge without reset, if MemWrite=1, mem[index] <= Data2.
REQ-021 On each rising edge without reset, registered outputs load:
- oldBranchAddress <= BranchAddress
- PCSrc <= B | (BZ & zero) | (BNZ & ~zero)
- oldRegWrite <= RegWrite
- Reg2Write <= Instruction[4:0]
- Data2Write <= (MemtoReg & MemRead) ? mem[index] : Results
REQ-022 Latency: inputs sampled at edge N appear on registered outputs immediately after edge N.
REQ-023 Read-before-write: a read at edge N returns memory contents from before any write at edge N, including the same-index case with MemRead=MemWrite=1.
REQ-024 MemtoReg=1 with MemRead=0 forwards Results, not memory.
REQ-025 Simultaneous branch flags: PCSrc is the OR of all qualified conditions.

Reset
REQ-026 When reset=1 at a rising edge:
- all registered outputs <= 0;
- all 32 memory words <= 0;
- writes requested in the same cycle are discarded.
REQ-027 ALUInst stays combinational and is unaffected by reset.

Configuration
REQ-028 With MEMACC_TRACE_EN defined, each completed memory write and memory read is reported via a simulation message giving index and data; without it, no messages are emitted. The macro changes no functional behaviour.

Structure
REQ-029 Shared package holds:
- ALU code constants: AND 0000, ORR 0001, ADD 0010, SUB 0110, PASSB 0111, NOR 1100, INVALID 1111;
- opcode constants;
- memory depth 32 and index width 5.
REQ-030 ALU decode lives in one sub-module, alu_ctrl_decode; memory and pipeline registers stay in the top.

Verification
REQ-031 Store then load:
- MemWrite=1, Results=0x10, Data2=0xDEAD;
- next cycle MemRead=MemtoReg=1, Results=0x10;
- -> Data2Write=0xDEAD.
REQ-032 Branch decode (each with BranchAddress=0x40):
- BZ=1, zero=1 -> PCSrc=1, oldBranchAddress=0x40;
- BZ=1, zero=0 -> PCSrc=0;
- BNZ=1, zero=0 -> PCSrc=1;
- B=1 -> PCSrc=1.
REQ-033 ALU decode, Instruction[31:21] and ALUOp:
- 11001011000, ALUOp 10 -> ALUInst=0110;
- 1001000100x, ALUOp 11 -> ALUInst=0010;
- ALUOp 01 -> ALUInst=0111;
- 11111111111, ALUOp 10 -> ALUInst=1111.
REQ-034 Forward path: MemtoReg=0, Results=0x1234, RegWrite=1, Instruction[4:0]=9 -> Data2Write=0x1234, oldRegWrite=1, Reg2Write=9.
REQ-035 Reset mid-operation:
- write 0x55 to index 2;
- assert reset with MemWrite=1;
- -> all outputs 0;
- a subsequent read of index 2 returns 0.
REQ-036 Address wrap: write to Results=0x108 -> a read of Results=0x008 returns the written data.

Source files
------------

// File: rtl/memory_access_stage_pkg.sv
// memory_access_stage_pkg: ALU control codes, opcodes and memory geometry for the memory access stage.
package memory_access_stage_pkg;
   localparam logic [3:0] ALU_AND     = 4'b0000;
   localparam logic [3:0] ALU_ORR     = 4'b0001;
   localparam logic [3:0] ALU_ADD     = 4'b0010;
   localparam logic [3:0] ALU_SUB     = 4'b0110;
   localparam logic [3:0] ALU_PASSB   = 4'b0111;
   localparam logic [3:0] ALU_NOR     = 4'b1100;
   localparam logic [3:0] ALU_INVALID = 4'b1111;

   typedef enum logic [1:0] {
      ALUOP_LDST = 2'b00,
      ALUOP_CB   = 2'b01,
      ALUOP_R    = 2'b10,
      ALUOP_I    = 2'b11
   } aluop_e;

   localparam logic [10:0] OP_ADD = 11'b10001011000;
   localparam logic [10:0] OP_SUB = 11'b11001011000;
   localparam logic [10:0] OP_AND = 11'b10001010000;
   localparam logic [10:0] OP_ORR = 11'b10101010000;

   // Immediate forms carry an immediate bit in op[0], so only op[10:1] is matched.
   localparam logic [9:0] OPI_ADDI = 10'b1001000100;
   localparam logic [9:0] OPI_SUBI = 10'b1101000100;
   localparam logic [9:0] OPI_ANDI = 10'b1001001000;
   localparam logic [9:0] OPI_ORRI = 10'b1011001000;

   localparam int MEM_DEPTH = 32;
   localparam int IDX_W     = 5;
endpackage

// File: rtl/memory_access_stage_alu_ctrl_decode.sv
// alu_ctrl_decode: combinational ALU operation decode from ALUOp class and instruction opcode.
module alu_ctrl_decode
   import memory_access_stage_pkg::*;
(
   input  logic [10:0] i_op,
   input  logic [1:0]  i_alu_op,
   output logic [3:0]  o_alu_inst
);
   logic [3:0] w_r_inst;
   logic [3:0] w_i_inst;
   always_comb begin
      w_r_inst = (i_op == OP_ADD) ? ALU_ADD :
                 (i_op == OP_SUB) ? ALU_SUB :
                 (i_op == OP_AND) ? ALU_AND :
                 (i_op == OP_ORR) ? ALU_ORR : ALU_INVALID;
      w_i_inst = (i_op[10:1] == OPI_ADDI) ? ALU_ADD :
                 (i_op[10:1] == OPI_SUBI) ? ALU_SUB :
                 (i_op[10:1] == OPI_ANDI) ? ALU_AND :
                 (i_op[10:1] == OPI_ORRI) ? ALU_ORR : ALU_INVALID;
      o_alu_inst = (i_alu_op == ALUOP_LDST) ? ALU_ADD   :
                   (i_alu_op == ALUOP_CB)   ? ALU_PASSB :
                   (i_alu_op == ALUOP_R)    ? w_r_inst  : w_i_inst;
   end
endmodule

// File: rtl/memory_access_stage.sv
// memory_access_stage: data memory, branch resolution and MEM/WB registers of a pipelined core.
// Define MEMACC_TRACE_EN to print a simulation message for every memory write and read.
module memory_access_stage
   import memory_access_stage_pkg::*;
(
   input  logic        clk,
   input  logic        reset,
   input  logic [31:0] Instruction,
   input  logic [63:0] BranchAddress,
   input  logic [63:0] Results,
   input  logic [63:0] Data2,
   input  logic        zero,
   input  logic        B,
   input  logic        BZ,
   input  logic        BNZ,
   input  logic        MemRead,
   input  logic        MemWrite,
   input  logic        MemtoReg,
   input  logic        RegWrite,
   input  logic [1:0]  ALUOp,
   output logic [3:0]  ALUInst,
   output logic [63:0] oldBranchAddress,
   output logic        PCSrc,
   output logic        oldRegWrite,
   output logic [63:0] Data2Write,
   output logic [4:0]  Reg2Write
);
   logic [63:0]      r_mem [MEM_DEPTH];
   logic [IDX_W-1:0] w_idx;
   logic             w_unused;

   // Doubleword-addressed: byte offset and upper address bits are dropped, so addresses wrap at 256.
   assign w_idx    = Results[7:3];
   assign w_unused = ^{Results[63:8], Results[2:0], Instruction[20:5]};

   alu_ctrl_decode u_alu_ctrl_decode (
      .i_op       (Instruction[31:21]),
      .i_alu_op   (ALUOp),
      .o_alu_inst (ALUInst)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < MEM_DEPTH; i++) r_mem[i] <= '0;
         oldBranchAddress <= '0;
         PCSrc            <= 1'b0;
         oldRegWrite      <= 1'b0;
         Data2Write       <= '0;
         Reg2Write        <= '0;
      end else begin
         if (MemWrite) r_mem[w_idx] <= Data2;
         oldBranchAddress <= BranchAddress;
         PCSrc            <= B | (BZ & zero) | (BNZ & ~zero);
         oldRegWrite      <= RegWrite;
         Reg2Write        <= Instruction[4:0];
         Data2Write       <= (MemtoReg & MemRead) ? r_mem[w_idx] : Results;
`ifdef MEMACC_TRACE_EN
         if (MemWrite) $display("memacc: write idx=%0d data=%h", w_idx, Data2);
         if (MemRead) $display("memacc: read idx=%0d data=%h", w_idx, r_mem[w_idx]);
`endif
      end
   end
endmodule

// File: tb/tb_memory_access_stage.sv
// tb_memory_access_stage: directed self-checking bench for memory_access_stage.
module tb_memory_access_stage;
   logic        clk = 1'b0;
   logic        reset;
   logic [31:0] Instruction;
   logic [63:0] BranchAddress, Results, Data2;
   logic        zero, B, BZ, BNZ, MemRead, MemWrite, MemtoReg, RegWrite;
   logic [1:0]  ALUOp;
   logic [3:0]  ALUInst;
   logic [63:0] oldBranchAddress, Data2Write;
   logic        PCSrc, oldRegWrite;
   logic [4:0]  Reg2Write;
   int errors = 0;
   int checks = 0;

   memory_access_stage dut (
      .clk(clk), .reset(reset), .Instruction(Instruction), .BranchAddress(BranchAddress),
      .Results(Results), .Data2(Data2), .zero(zero), .B(B), .BZ(BZ), .BNZ(BNZ),
      .MemRead(MemRead), .MemWrite(MemWrite), .MemtoReg(MemtoReg), .RegWrite(RegWrite),
      .ALUOp(ALUOp), .ALUInst(ALUInst), .oldBranchAddress(oldBranchAddress), .PCSrc(PCSrc),
      .oldRegWrite(oldRegWrite), .Data2Write(Data2Write), .Reg2Write(Reg2Write)
   );

   always #5 clk = ~clk;

   task automatic idle();
      reset = 0; Instruction = '0; BranchAddress = '0; Results = '0; Data2 = '0;
      zero = 0; B = 0; BZ = 0; BNZ = 0; MemRead = 0; MemWrite = 0; MemtoReg = 0;
      RegWrite = 0; ALUOp = 2'b00;
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      idle();
      reset = 1; BranchAddress = 64'hFFFF; Results = 64'h10; Data2 = 64'h99; MemWrite = 1;
      B = 1; RegWrite = 1; Instruction = 32'h1F; ALUOp = 2'b01;
      step();
      step();
      checks += 6;
      if (oldBranchAddress !== 64'h0) begin errors++; $display("FAIL reset_bra got=%h exp=0", oldBranchAddress); end
      if (PCSrc !== 1'b0) begin errors++; $display("FAIL reset_pcsrc got=%b exp=0", PCSrc); end
      if (oldRegWrite !== 1'b0) begin errors++; $display("FAIL reset_regwrite got=%b exp=0", oldRegWrite); end
      if (Data2Write !== 64'h0) begin errors++; $display("FAIL reset_data got=%h exp=0", Data2Write); end
      if (Reg2Write !== 5'h0) begin errors++; $display("FAIL reset_reg got=%h exp=0", Reg2Write); end
      if (ALUInst !== 4'b0111) begin errors++; $display("FAIL reset_aluinst got=%b exp=0111", ALUInst); end
      idle();
   endtask

   task automatic test_alu_decode();
      logic [10:0] ops [14] = '{11'b11001011000, 11'b10001011000, 11'b10001010000, 11'b10101010000,
                                11'b11111111111, 11'b10010001000, 11'b10010001001, 11'b11010001001,
                                11'b10010010000, 11'b10110010001, 11'b11111111111, 11'b00000000000,
                                11'b11111111111, 11'b10001011001};
      logic [1:0] aops [14] = '{2'b10, 2'b10, 2'b10, 2'b10, 2'b10, 2'b11, 2'b11, 2'b11,
                                2'b11, 2'b11, 2'b11, 2'b01, 2'b00, 2'b10};
      logic [3:0] exps [14] = '{4'b0110, 4'b0010, 4'b0000, 4'b0001, 4'b1111, 4'b0010, 4'b0010,
                                4'b0110, 4'b0000, 4'b0001, 4'b1111, 4'b0111, 4'b0010, 4'b1111};
      for (int i = 0; i < 14; i++) begin
         Instruction = {ops[i], 21'h0};
         ALUOp = aops[i];
         #1;
         checks++;
         if (ALUInst !== exps[i]) begin
            errors++;
            $display("FAIL alu_decode[%0d] op=%b aluop=%b got=%b exp=%b", i, ops[i], aops[i], ALUInst, exps[i]);
         end
      end
      idle();
   endtask

   task automatic test_store_load();
      MemWrite = 1; Results = 64'h10; Data2 = 64'hDEAD;
      step();
      checks++;
      if (Data2Write !== 64'h10) begin errors++; $display("FAIL store_fwd got=%h exp=10", Data2Write); end
      idle();
      MemRead = 1; MemtoReg = 1; Results = 64'h10;
      step();
      checks++;
      if (Data2Write !== 64'hDEAD) begin errors++; $display("FAIL store_load got=%h exp=dead", Data2Write); end
      idle();
   endtask

   task automatic test_branch();
      logic [3:0] vec [6] = '{4'b0101, 4'b0100, 4'b0010, 4'b1000, 4'b0111, 4'b0000};
      logic       exp [6] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
      for (int i = 0; i < 6; i++) begin
         {B, BZ, BNZ, zero} = vec[i];
         BranchAddress = 64'h40 + 64'(i);
         step();
         checks += 2;
         if (PCSrc !== exp[i]) begin errors++; $display("FAIL branch[%0d] pcsrc got=%b exp=%b", i, PCSrc, exp[i]); end
         if (oldBranchAddress !== 64'h40 + 64'(i)) begin
            errors++; $display("FAIL branch[%0d] addr got=%h exp=%h", i, oldBranchAddress, 64'h40 + 64'(i));
         end
      end
      idle();
   endtask

   task automatic test_forward();
      Results = 64'h1234; RegWrite = 1; Instruction = 32'h9;
      step();
      checks += 3;
      if (Data2Write !== 64'h1234) begin errors++; $display("FAIL fwd_data got=%h exp=1234", Data2Write); end
      if (oldRegWrite !== 1'b1) begin errors++; $display("FAIL fwd_regwrite got=%b exp=1", oldRegWrite); end
      if (Reg2Write !== 5'd9) begin errors++; $display("FAIL fwd_reg got=%0d exp=9", Reg2Write); end
      idle();
      MemtoReg = 1; MemRead = 0; Results = 64'h10;
      step();
      checks++;
      if (Data2Write !== 64'h10) begin errors++; $display("FAIL memtoreg_noread got=%h exp=10", Data2Write); end
      idle();
   endtask

   task automatic test_read_before_write();
      MemRead = 1; MemtoReg = 1; MemWrite = 1; Results = 64'h10; Data2 = 64'hBEEF;
      step();
      checks++;
      if (Data2Write !== 64'hDEAD) begin errors++; $display("FAIL rbw_old got=%h exp=dead", Data2Write); end
      MemWrite = 0;
      step();
      checks++;
      if (Data2Write !== 64'hBEEF) begin errors++; $display("FAIL rbw_new got=%h exp=beef", Data2Write); end
      idle();
   endtask

   task automatic test_reset_mid();
      MemWrite = 1; Results = 64'h10; Data2 = 64'h55;
      step();
      reset = 1; Data2 = 64'h77; B = 1; RegWrite = 1; Instruction = 32'h7; BranchAddress = 64'h80;
      step();
      checks += 5;
      if (oldBranchAddress !== 64'h0) begin errors++; $display("FAIL rmid_bra got=%h exp=0", oldBranchAddress); end
      if (PCSrc !== 1'b0) begin errors++; $display("FAIL rmid_pcsrc got=%b exp=0", PCSrc); end
      if (oldRegWrite !== 1'b0) begin errors++; $display("FAIL rmid_regwrite got=%b exp=0", oldRegWrite); end
      if (Data2Write !== 64'h0) begin errors++; $display("FAIL rmid_data got=%h exp=0", Data2Write); end
      if (Reg2Write !== 5'h0) begin errors++; $display("FAIL rmid_reg got=%h exp=0", Reg2Write); end
      idle();
      MemRead = 1; MemtoReg = 1; Results = 64'h10;
      step();
      checks++;
      if (Data2Write !== 64'h0) begin errors++; $display("FAIL rmid_mem got=%h exp=0", Data2Write); end
      idle();
   endtask

   task automatic test_address_wrap();
      MemWrite = 1; Results = 64'h108; Data2 = 64'hA5A5;
      step();
      idle();
      MemRead = 1; MemtoReg = 1; Results = 64'h008;
      step();
      checks++;
      if (Data2Write !== 64'hA5A5) begin errors++; $display("FAIL wrap_low got=%h exp=a5a5", Data2Write); end
      Results = 64'hFFFF_FFFF_FFFF_FF0F;
      step();
      checks++;
      if (Data2Write !== 64'hA5A5) begin errors++; $display("FAIL wrap_high got=%h exp=a5a5", Data2Write); end
      idle();
   endtask

   task automatic test_back_to_back();
      for (int i = 0; i < 4; i++) begin
         MemWrite = 1; Results = 64'((i + 3) * 8); Data2 = 64'h1000 + 64'(i);
         step();
      end
      idle();
      for (int i = 0; i < 4; i++) begin
         MemRead = 1; MemtoReg = 1; Results = 64'((i + 3) * 8);
         step();
         checks++;
         if (Data2Write !== 64'h1000 + 64'(i)) begin
            errors++; $display("FAIL b2b[%0d] got=%h exp=%h", i, Data2Write, 64'h1000 + 64'(i));
         end
      end
      idle();
   endtask

   initial begin
      idle();
      test_reset();
      test_alu_decode();
      test_store_load();
      test_branch();
      test_forward();
      test_read_before_write();
      test_reset_mid();
      test_address_wrap();
      test_back_to_back();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
